key_press_gen: RTL and testbench

//   Synthesizable key-press emulator: drives an active-low, bouncing key waveform,
//   i.e. the transmitting end of the key_in interface that the debouncer receives.
//   One start request produces press bounce, clean hold, release bounce, then idle-high.

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_press_gen_lfsr16.sv | 37 +++
 rtl/key_press_gen.sv | 154 +++++++++++++++
 tb/tb_key_press_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
//   Shared definitions for the key-press emulator: FSM state encoding, the
//   LFSR feedback tap mask, the fallback seed and the LFSR step function.
// ---------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPressBnc,
        StHold,
        StRelBnc,
        StDone
    } key_state_e;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Shift left, feedback enters at bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/key_press_gen_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   16-bit maximal-length Fibonacci LFSR used as the chatter source.
// Ports
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-high reset, loads the seed
//   i_en    advance one step this cycle
//   i_seed  reset value; zero is replaced so the register never locks up
//   o_q     current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
    import key_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [15:0] i_seed,
    output logic [15:0] o_q
);

    logic [15:0] r_q;
    logic [15:0] w_seed;

    // An all-zero state is a fixed point of the feedback, so it is never loaded.
    assign w_seed = (i_seed == 16'h0000) ? LFSR_DEFAULT_SEED : i_seed;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= w_seed;
        end else if (i_en) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/key_press_gen.sv
// ---------------------------------------------------------------------------
// key_press_gen
//   Emulates an active-low mechanical key: one accepted start produces press
//   chatter, a clean low hold, release chatter, then a one-cycle done pulse.
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_start        press request, only honoured in idle
//   i_hold_cycles  clean-low length, latched on accepted start (0 acts as 1)
//   o_busy         high for every waveform cycle (chatter + hold)
//   o_done         one-cycle pulse the cycle after o_busy falls
//   o_key_n        emulated key level, registered
// ---------------------------------------------------------------------------
module key_press_gen
    import key_pkg::*;
#(
    parameter int unsigned BOUNCE_CYC = 20,
    parameter int unsigned HOLD_W     = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [HOLD_W-1:0] i_hold_cycles,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_key_n
);

    localparam int unsigned BNC_W   = $clog2(BOUNCE_CYC + 1);
    localparam int unsigned CNT_W   = (BNC_W > HOLD_W) ? BNC_W : HOLD_W;
    localparam bit          HAS_BNC = (BOUNCE_CYC != 0);
    localparam logic [CNT_W-1:0] BNC_LAST = HAS_BNC ? CNT_W'(BOUNCE_CYC - 1) : '0;

    key_state_e        r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [HOLD_W-1:0] r_hold, w_hold_next;
    logic [HOLD_W-1:0] w_hold_last;
    logic              r_busy, r_done, r_key_n;
    logic              w_busy_next, w_done_next, w_key_n_next;
    logic [15:0]       w_lfsr_q;
    logic              w_unused_lfsr;

    // Only bit 0 drives the key; the rest is kept for observability.
    assign w_unused_lfsr = ^w_lfsr_q[15:1];

    // Last counter value of the hold phase; zero hold behaves as one cycle.
    assign w_hold_last = (r_hold == '0) ? '0 : r_hold - 1'b1;

    // LFSR steps on every waveform cycle so each burst differs from the last.
    lfsr16 u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_busy_next),
        .i_seed (LFSR_SEED),
        .o_q    (w_lfsr_q)
    );

    // State, counter and latched hold length.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_hold  <= w_hold_next;
        end
    end

    // Next-state logic; the counter restarts at zero on every phase change.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_hold_next  = r_hold;
        case (r_state)
            StIdle: begin
                w_cnt_next = '0;
                if (i_start) begin
                    w_hold_next  = i_hold_cycles;
                    w_state_next = HAS_BNC ? StPressBnc : StHold;
                end
            end
            StPressBnc: begin
                if (r_cnt == BNC_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = StHold;
                end
            end
            StHold: begin
                if (r_cnt == CNT_W'(w_hold_last)) begin
                    w_cnt_next   = '0;
                    w_state_next = HAS_BNC ? StRelBnc : StDone;
                end
            end
            StRelBnc: begin
                if (r_cnt == BNC_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_cnt_next   = '0;
                w_state_next = StIdle;
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = StIdle;
            end
        endcase
    end

    // Output decode from the current state; registered below, hence the
    // one-cycle lag between a state and its visible waveform bit.
    always_comb begin
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        w_key_n_next = 1'b1;
        case (r_state)
            StPressBnc, StRelBnc: begin
                w_busy_next  = 1'b1;
                w_key_n_next = w_lfsr_q[0];
            end
            StHold: begin
                w_busy_next  = 1'b1;
                w_key_n_next = 1'b0;
            end
            StDone: begin
                w_done_next = 1'b1;
            end
            default: begin
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_key_n <= 1'b1;
        end else begin
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_key_n <= w_key_n_next;
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_key_n = r_key_n;

endmodule

// File: tb/tb_key_press_gen.sv
// ---------------------------------------------------------------------------
// tb_key_press_gen
//   Two instances: u_dut_a with 20 chatter cycles, u_dut_b with no chatter.
//   Press vectors come from a table; reset behaviour and the mid-press reset
//   are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_key_press_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [15:0] hold_a, hold_b;
    logic        busy_a, done_a, key_a;
    logic        busy_b, done_b, key_b;

    always #5 clk = ~clk;

    key_press_gen #(
        .BOUNCE_CYC (20),
        .HOLD_W     (16),
        .LFSR_SEED  (16'hACE1)
    ) u_dut_a (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start_a),
        .i_hold_cycles (hold_a),
        .o_busy        (busy_a),
        .o_done        (done_a),
        .o_key_n       (key_a)
    );

    key_press_gen #(
        .BOUNCE_CYC (0),
        .HOLD_W     (16),
        .LFSR_SEED  (16'hACE1)
    ) u_dut_b (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start_b),
        .i_hold_cycles (hold_b),
        .o_busy        (busy_b),
        .o_done        (done_b),
        .o_key_n       (key_b)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_lfsr;

    typedef struct {
        bit          use_b;
        logic [15:0] hold;
        int          retrig;
        int          exp_busy;
        string       name;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, shifting left.
    function automatic logic [15:0] model_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    task automatic run_press(input vec_t v);
        int   bnc;
        int   busy_cnt;
        int   first_busy;
        int   done_cnt;
        int   done_pos;
        int   wave_err;
        logic b, d, kn, exp_k;
        bnc        = v.use_b ? 0 : 20;
        busy_cnt   = 0;
        first_busy = -1;
        done_cnt   = 0;
        done_pos   = -1;
        wave_err   = 0;
        @(negedge clk);
        if (v.use_b) begin start_b = 1'b1; hold_b = v.hold; end
        else begin start_a = 1'b1; hold_a = v.hold; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        b = v.use_b ? busy_b : busy_a;
        check({v.name, "_latency_busy"}, b, 0);
        // Changing hold mid-press must not affect the latched length.
        hold_a = 16'd7;
        hold_b = 16'd7;
        for (int k = 0; k < v.exp_busy + 8; k++) begin
            @(negedge clk);
            b  = v.use_b ? busy_b : busy_a;
            d  = v.use_b ? done_b : done_a;
            kn = v.use_b ? key_b  : key_a;
            if (b) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = k;
            end
            if (d) begin
                done_cnt++;
                done_pos = k;
            end
            if (k < v.exp_busy) begin
                exp_k = (k < bnc || k >= v.exp_busy - bnc) ? m_lfsr[0] : 1'b0;
                if (!v.use_b) m_lfsr = model_step(m_lfsr);
            end else begin
                exp_k = 1'b1;
            end
            if (kn !== exp_k) wave_err++;
            if (k == v.retrig) begin
                if (v.use_b) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check({v.name, "_busy_len"}, busy_cnt, v.exp_busy);
        check({v.name, "_busy_start"}, first_busy, 0);
        check({v.name, "_done_count"}, done_cnt, 1);
        check({v.name, "_done_pos"}, done_pos, v.exp_busy);
        check({v.name, "_wave_errs"}, wave_err, 0);
    endtask

    initial begin
        int   bad;
        vec_t after_rst;

        // use_b, hold, retrig cycle (-1 none), expected busy cycles, name
        vecs[0] = '{1'b0, 16'd100, -1, 140, "b20_h100"};
        vecs[1] = '{1'b0, 16'd100, 30, 140, "b20_h100_retrig"};
        vecs[2] = '{1'b0, 16'd0,   -1,  41, "b20_h0"};
        vecs[3] = '{1'b0, 16'd1,   -1,  41, "b20_h1"};
        vecs[4] = '{1'b0, 16'd3,   -1,  43, "b20_h3"};
        vecs[5] = '{1'b1, 16'd0,   -1,   1, "b0_h0"};
        vecs[6] = '{1'b1, 16'd5,   -1,   5, "b0_h5"};

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        hold_a  = '0;
        hold_b  = '0;
        repeat (3) @(negedge clk);
        check("rst_key_n", key_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_key_n_b", key_b, 1);
        rst    = 1'b0;
        m_lfsr = 16'hACE1;

        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (key_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
            if (key_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) bad++;
        end
        check("idle_after_rst", bad, 0);

        for (int i = 0; i < 7; i++) run_press(vecs[i]);

        // Reset in the middle of the hold phase.
        @(negedge clk);
        start_a = 1'b1;
        hold_a  = 16'd100;
        @(negedge clk);
        start_a = 1'b0;
        repeat (60) @(negedge clk);
        check("pre_rst_busy", busy_a, 1);
        check("pre_rst_key_n", key_a, 0);
        rst = 1'b1;
        #1;
        check("midrst_key_n", key_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_lfsr = 16'hACE1;
        bad    = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0 || key_a !== 1'b1) bad++;
        end
        check("midrst_quiet", bad, 0);

        after_rst = '{1'b0, 16'd100, -1, 140, "after_rst"};
        run_press(after_rst);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
